// File: rtl/precharge_bus_sequencer.sv
// Precharge/evaluate/latch sequencer modelling a wired-AND dynamic bus.
// Optional driver-disagreement detection is compiled in with BUS_CONTENTION_CHECK_EN.
module precharge_bus_sequencer #(
   parameter int WIDTH       = 8,
   parameter int NDRV        = 4,
   parameter int EVAL_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NDRV-1:0]         drv_en,
   input  logic [NDRV*WIDTH-1:0]   drv_data,
   output logic [WIDTH-1:0]        bus,
   output logic [1:0]              phase,
   output logic                    busy,
   output logic [WIDTH-1:0]        q,
   output logic                    q_valid,
   output logic                    contention
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRECHARGE = 2'd1,
      EVALUATE  = 2'd2,
      LATCH     = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt;
   logic [NDRV-1:0]         en_cap;
   logic [NDRV*WIDTH-1:0]   data_cap;
   logic [WIDTH-1:0]        bus_r;
   logic [WIDTH-1:0]        q_r;

   // Undriven bus lines stay precharged high; any enabled driver can pull a bit low.
   function automatic logic [WIDTH-1:0] wired_and(input logic [NDRV-1:0]       en,
                                                   input logic [NDRV*WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = '1;
      for (int i = 0; i < NDRV; i++)
         if (en[i]) r = r & d[i*WIDTH +: WIDTH];
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start) state_nxt = PRECHARGE;
         PRECHARGE: state_nxt = EVALUATE;
         EVALUATE:  if (cnt == 4'd1) state_nxt = LATCH;
         LATCH:     state_nxt = start ? PRECHARGE : IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         en_cap   <= '0;
         data_cap <= '0;
         bus_r    <= '1;
         q_r      <= '0;
      end else begin
         state <= state_nxt;
         if (state == PRECHARGE) begin
            en_cap   <= drv_en;
            data_cap <= drv_data;
            cnt      <= 4'(EVAL_CYCLES);
            bus_r    <= wired_and(drv_en, drv_data);
         end else if (state == EVALUATE) begin
            cnt <= cnt - 4'd1;
            if (state_nxt == LATCH) q_r <= wired_and(en_cap, data_cap);
         end else if (state_nxt == IDLE || state_nxt == PRECHARGE) begin
            bus_r <= '1;
         end
      end
   end

`ifdef BUS_CONTENTION_CHECK_EN
   logic cont_r;

   // Enabled drivers disagree exactly when their AND and OR differ in some bit.
   function automatic logic disagree(input logic [NDRV-1:0]       en,
                                      input logic [NDRV*WIDTH-1:0] d);
      logic [WIDTH-1:0] a, o;
      a = '1;
      o = '0;
      for (int i = 0; i < NDRV; i++)
         if (en[i]) begin
            a = a & d[i*WIDTH +: WIDTH];
            o = o | d[i*WIDTH +: WIDTH];
         end
      return (|en) && (a != o);
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         cont_r <= 1'b0;
      else if (state == PRECHARGE && disagree(drv_en, drv_data))
         cont_r <= 1'b1;
   end

   assign contention = cont_r;
`else
   assign contention = 1'b0;
`endif

   assign bus     = bus_r;
   assign q       = q_r;
   assign phase   = state;
   assign busy    = (state != IDLE);
   assign q_valid = (state == LATCH);

endmodule

// File: tb/tb_precharge_bus_sequencer.sv
// Directed bench for precharge_bus_sequencer; latched results are checked by a
// scoreboard monitor that compares value and arrival cycle on every q_valid.
module tb_precharge_bus_sequencer;
   localparam int WIDTH = 8;
   localparam int NDRV  = 4;
   localparam int EVAL  = 2;
`ifdef BUS_CONTENTION_CHECK_EN
   localparam logic CONT_EN = 1'b1;
`else
   localparam logic CONT_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  start = 1'b0;
   logic [NDRV-1:0]       drv_en = '0;
   logic [NDRV*WIDTH-1:0] drv_data = '0;
   logic [WIDTH-1:0]      bus;
   logic [1:0]            phase;
   logic                  busy;
   logic [WIDTH-1:0]      q;
   logic                  q_valid;
   logic                  contention;

   precharge_bus_sequencer #(.WIDTH(WIDTH), .NDRV(NDRV), .EVAL_CYCLES(EVAL)) dut (
      .clk(clk), .reset(reset), .start(start), .drv_en(drv_en), .drv_data(drv_data),
      .bus(bus), .phase(phase), .busy(busy), .q(q), .q_valid(q_valid),
      .contention(contention)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0] q;
      int               cyc;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every q_valid must match the oldest expected result, in value and cycle.
   always @(negedge clk) begin
      if (q_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_q_valid: got q=%0h with no pending request (cycle %0d)", q, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("q_value", q, e.q);
            chk("q_valid_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Presents drivers and a one-cycle start pulse; returns in the PRECHARGE cycle.
   task automatic issue(input logic [NDRV-1:0] en, input logic [NDRV*WIDTH-1:0] data,
                        input logic [WIDTH-1:0] expq, input bit push);
      drv_en   = en;
      drv_data = data;
      start    = 1'b1;
      if (push) sb.push_back('{q: expq, cyc: cyc + 2 + EVAL});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_txn(input string name, input logic [NDRV-1:0] en,
                          input logic [NDRV*WIDTH-1:0] data,
                          input logic [WIDTH-1:0] expq, input logic expc);
      issue(en, data, expq, 1'b1);
      chk({name, "_pre_phase"}, phase, 32'd1);
      chk({name, "_pre_bus"}, bus, 32'hFF);
      repeat (EVAL) begin
         @(negedge clk);
         chk({name, "_eval_phase"}, phase, 32'd2);
         chk({name, "_eval_bus"}, bus, expq);
         chk({name, "_eval_contention"}, contention, expc);
      end
      @(negedge clk);
      chk({name, "_latch_phase"}, phase, 32'd3);
      chk({name, "_latch_bus"}, bus, expq);
      @(negedge clk);
      chk({name, "_idle_phase"}, phase, 32'd0);
      chk({name, "_idle_bus"}, bus, 32'hFF);
      chk({name, "_idle_busy"}, busy, 32'd0);
   endtask

   initial begin
      // Reset, then idle
      do_reset();
      repeat (5) @(negedge clk);
      chk("rst_bus", bus, 32'hFF);
      chk("rst_phase", phase, 32'd0);
      chk("rst_q", q, 32'd0);
      chk("rst_q_valid", q_valid, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_contention", contention, 32'd0);

      // Two drivers wired-AND: F0 & 3C = 30 (they disagree)
      run_txn("and2", 4'b0011, {8'h00, 8'h00, 8'h3C, 8'hF0}, 8'h30, CONT_EN);
      chk("and2_q_hold", q, 32'h30);
      repeat (3) @(negedge clk);
      chk("and2_cont_sticky", contention, CONT_EN);
      do_reset();
      chk("cont_cleared", contention, 32'd0);
      chk("reset_q", q, 32'd0);

      // Boundary drivers, single enabled driver and agreeing pair
      run_txn("drv3", 4'b1000, {8'h0F, 8'h00, 8'h00, 8'h00}, 8'h0F, 1'b0);
      run_txn("same2", 4'b0110, {8'h00, 8'hC3, 8'hC3, 8'h00}, 8'hC3, 1'b0);
      chk("no_cont", contention, 32'd0);

      // No drivers, then drivers change mid-EVALUATE
      issue(4'b0000, 32'h1234_5678, 8'hFF, 1'b1);
      @(negedge clk);
      drv_en   = 4'b1111;
      drv_data = '0;
      chk("noen_bus_e1", bus, 32'hFF);
      @(negedge clk);
      chk("noen_bus_e2", bus, 32'hFF);
      @(negedge clk);
      chk("noen_latch_bus", bus, 32'hFF);
      @(negedge clk);
      chk("noen_cont", contention, 32'd0);
      do_reset();

      // start held high: back-to-back transactions with no IDLE gap
      drv_en   = 4'b0001;
      drv_data = {8'h00, 8'h00, 8'h00, 8'h5A};
      start    = 1'b1;
      for (int k = 0; k < 3; k++) sb.push_back('{q: 8'h5A, cyc: cyc + 2 + EVAL + k * (EVAL + 2)});
      repeat (3 * (EVAL + 2)) begin
         @(negedge clk);
         chk("b2b_busy", busy, 32'd1);
      end
      start = 1'b0;
      @(negedge clk);
      chk("b2b_end_phase", phase, 32'd0);

      // Reset in the first EVALUATE cycle aborts the transaction
      issue(4'b0011, {8'h00, 8'h00, 8'h0F, 8'h3F}, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_phase", phase, 32'd0);
      chk("abort_bus", bus, 32'hFF);
      chk("abort_q", q, 32'd0);
      chk("abort_q_valid", q_valid, 32'd0);
      repeat (EVAL + 3) @(negedge clk);

      // Opposite patterns: contention from EVALUATE on, sticky until reset
      run_txn("cont", 4'b0011, {8'h00, 8'h00, 8'h55, 8'hAA}, 8'h00, CONT_EN);
      repeat (4) @(negedge clk);
      chk("cont_after_idle", contention, CONT_EN);
      do_reset();
      chk("cont_reset", contention, 32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
